mult_issue_ctrl: RTL and testbench
==================================

Name: mult_issue_ctrl

Overview:
- RTL issuer placed directly upstream of the parity-protected 16x16 signed multiplier.
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- For each pair it generates even parity, drives the multiplier req/ack handshake, waits for result_rdy, checks the result parity, and returns the result with status on a valid/ready output stream.
- One transaction is in flight at a time.

Parameters:
- FIFO_DEPTH, 4: operand FIFO entries; must be a power of 2, ≥2.
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ+WAIT_RES before the transaction is aborted.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept; equals !full.
- in_a  in  16  signed operand A.
- in_b  in  16  signed operand B.
- in_flip_pa  in  1  invert generated A parity (error injection).
- in_flip_pb  in  1  invert generated B parity (error injection).
- req  out  1  arguments valid to multiplier.
- arg_a  out  16  operand A to multiplier.
- arg_b  out  16  operand B to multiplier.
- arg_a_parity  out  1  even parity of arg_a: ^arg_a, XOR in_flip_pa.
- arg_b_parity  out  1  even parity of arg_b: ^arg_b, XOR in_flip_pb.
- ack  in  1  multiplier accepted the arguments.
- result  in  32  signed product.
- result_parity  in  1  even parity of result.
- result_rdy  in  1  result valid (pulse).
- arg_parity_error  in  1  multiplier detected argument parity error.
- out_valid  out  1  output result valid.
- out_ready  in  1  consumer accepts.
- out_result  out  32  captured product.
- out_status  out  3  [2]=timeout, [1]=result parity bad, [0]=arg_parity_error.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.

Behaviour:
- Reset (rst=1 at posedge) sets all outputs to 0, except in_ready=1. It empties the FIFO, clears the timeout counter and sets the FSM to IDLE. This applies from any state; a mid-operation transaction is discarded. ack and result_rdy arriving after reset are ignored while in IDLE.
- FIFO:
  - Push when in_valid && in_ready. Stored fields are {in_a, in_b, in_flip_pa, in_flip_pb}. Pointers wrap modulo FIFO_DEPTH.
  - Pop occurs only in IDLE when non-empty and out_valid=0.
  - Simultaneous push and pop in the same cycle is legal and leaves the count unchanged.
  - in_ready is low while full.
- FSM states: IDLE, REQ, WAIT_RES, DONE.
  - IDLE: when FIFO non-empty, pop the head into the arg registers, compute parities and set req=1. Next state REQ. Latency: an entry pushed at edge N produces req=1 after edge N+1 (an empty FIFO is not bypassed).
  - REQ: req and all arg/parity outputs are held stable. The timeout counter increments each cycle.
    - On ack=1 at a posedge: req←0, go to WAIT_RES.
    - If ack and result_rdy are both 1 at the same edge: capture the result and go directly to DONE.
  - WAIT_RES: req=0 and the counter keeps incrementing. On result_rdy=1: capture out_result=result and set out_status:
    - [0] = arg_parity_error;
    - [1] = (^result != result_parity);
    - [2] = 0.
    - Then out_valid←1 and go to DONE.
  - Timeout: when the counter reaches TIMEOUT_CYCLES in REQ or WAIT_RES:
    - req←0, out_result←0, out_status←3'b100, out_valid←1, go to DONE.
    - A late ack/result_rdy received in DONE or IDLE is ignored.
  - DONE: out_valid=1 with out_result and out_status stable until out_ready=1 at a posedge. Then out_valid←0, counter←0, go to IDLE. No new req is issued while out_valid=1.
- Arithmetic: parity is the XOR-reduction over all bits. The product is not recomputed or checked here, only its parity.
- ack seen in IDLE, WAIT_RES or DONE is ignored. result_rdy seen in IDLE, REQ (without ack) or DONE is ignored.

Test Plan:
- Push a=3, b=-2 (0xFFFE) with no flips; the model returns 0xFFFFFFFA with parity 0 → arg_a_parity=0, arg_b_parity=1, req held until ack; out_result=0xFFFFFFFA, out_status=000, one out_valid transaction.
- Push a=1, b=1 with in_flip_pa=1 → arg_a_parity=0; the model returns result_rdy with arg_parity_error=1 and result 0 → out_status=001.
- Model returns 0x00000001 with result_parity=0 → out_status=010, out_result=0x00000001.
- FIFO_DEPTH=4, ack held 0, push 6 pairs back-to-back → 5 accepted (1 in flight plus 4 buffered), in_ready=0 on the 6th until the first completes; results then emerge in push order.
- TIMEOUT_CYCLES=16, ack never asserted → req falls after 16 cycles in REQ; out_valid=1 with out_result=0 and out_status=100; a later ack has no effect.
- Assert rst in WAIT_RES, then have the model raise result_rdy 2 cycles later → after the reset edge req=0, out_valid=0, in_ready=1, busy=0, and no output transaction results. Separately, with out_ready=0 for 10 cycles in DONE → outputs stay stable and no req is issued.

Source files
------------

// File: rtl/mult_issue_ctrl.sv
// Issue controller for the parity-protected 16x16 multiplier. Operand pairs are
// buffered in a small FIFO and issued one at a time. Each result is returned with status.
module mult_issue_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_flip_pa,
    input  logic        in_flip_pb,
    output logic        req,
    output logic [15:0] arg_a,
    output logic [15:0] arg_b,
    output logic        arg_a_parity,
    output logic        arg_b_parity,
    input  logic        ack,
    input  logic [31:0] result,
    input  logic        result_parity,
    input  logic        result_rdy,
    input  logic        arg_parity_error,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [2:0]  out_status,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RES, DONE} state_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        fpa;
        logic        fpb;
    } entry_t;

    entry_t        mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push, pop, full, empty;
    entry_t        head;

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic [15:0]   arg_a_q, arg_a_d, arg_b_q, arg_b_d;
    logic          pa_q, pa_d, pb_q, pb_d;
    logic [TW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          tmo;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_result_q, out_result_d;
    logic [2:0]    out_status_q, out_status_d;

    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == IDLE) && !empty && !out_valid_q;
    assign head     = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_a, in_b, in_flip_pa, in_flip_pb};
    end

    // Timeout wins over a same-edge ack/result so the bound is never exceeded.
    assign cnt_inc = cnt_q + TW'(1);
    assign tmo     = (cnt_inc >= TW'(TIMEOUT_CYCLES));

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        arg_a_d      = arg_a_q;
        arg_b_d      = arg_b_q;
        pa_d         = pa_q;
        pb_d         = pb_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_status_d = out_status_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    arg_a_d = head.a;
                    arg_b_d = head.b;
                    pa_d    = (^head.a) ^ head.fpa;
                    pb_d    = (^head.b) ^ head.fpb;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ, WAIT_RES: begin
                cnt_d = cnt_inc;
                if (tmo) begin
                    req_d        = 1'b0;
                    out_result_d = '0;
                    out_status_d = 3'b100;
                    out_valid_d  = 1'b1;
                    state_d      = DONE;
                end else if ((state_q == REQ && ack && result_rdy) ||
                             (state_q == WAIT_RES && result_rdy)) begin
                    req_d        = 1'b0;
                    out_result_d = result;
                    out_status_d = {1'b0, (^result) != result_parity, arg_parity_error};
                    out_valid_d  = 1'b1;
                    state_d      = DONE;
                end else if (state_q == REQ && ack) begin
                    req_d   = 1'b0;
                    state_d = WAIT_RES;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            arg_a_q      <= '0;
            arg_b_q      <= '0;
            pa_q         <= 1'b0;
            pb_q         <= 1'b0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_status_q <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            arg_a_q      <= arg_a_d;
            arg_b_q      <= arg_b_d;
            pa_q         <= pa_d;
            pb_q         <= pb_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_status_q <= out_status_d;
        end
    end

    assign req          = req_q;
    assign arg_a        = arg_a_q;
    assign arg_b        = arg_b_q;
    assign arg_a_parity = pa_q;
    assign arg_b_parity = pb_q;
    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_status   = out_status_q;
    assign busy         = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl: a hand-driven multiplier model and
// hand-computed expectations. The timeout is shortened to 16 cycles.
module tb_mult_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [15:0] in_a, in_b;
    logic        in_flip_pa, in_flip_pb;
    logic        req;
    logic [15:0] arg_a, arg_b;
    logic        arg_a_parity, arg_b_parity;
    logic        ack;
    logic [31:0] result;
    logic        result_parity, result_rdy, arg_parity_error;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_status;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    mult_issue_ctrl #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_flip_pa(in_flip_pa), .in_flip_pb(in_flip_pb),
        .req(req), .arg_a(arg_a), .arg_b(arg_b),
        .arg_a_parity(arg_a_parity), .arg_b_parity(arg_b_parity),
        .ack(ack), .result(result), .result_parity(result_parity),
        .result_rdy(result_rdy), .arg_parity_error(arg_parity_error),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_status(out_status), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push1(input logic [15:0] a, input logic [15:0] b,
                         input logic fa, input logic fb);
        in_valid = 1'b1; in_a = a; in_b = b; in_flip_pa = fa; in_flip_pb = fb;
        tick();
        in_valid = 1'b0; in_flip_pa = 1'b0; in_flip_pb = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20 && req !== 1'b1; i++) tick();
        chk("req_seen", req, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; in_flip_pa = 0; in_flip_pb = 0;
        ack = 0; result = 0; result_parity = 0; result_rdy = 0; arg_parity_error = 0;
        out_ready = 0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_req", req, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_status", out_status, 0);
        chk("rst_arg_a", arg_a, 0);

        // 3 * -2, clean parities
        push1(16'd3, 16'hFFFE, 0, 0);
        chk("t1_no_bypass", req, 0);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_req", req, 1);
        chk("t1_arg_a", arg_a, 32'h3);
        chk("t1_arg_b", arg_b, 32'hFFFE);
        chk("t1_pa", arg_a_parity, 0);
        chk("t1_pb", arg_b_parity, 1);
        for (int i = 0; i < 3; i++) tick();
        chk("t1_req_held", req, 1);
        chk("t1_arg_a_held", arg_a, 32'h3);
        ack = 1; tick(); ack = 0;
        chk("t1_req_drop", req, 0);
        chk("t1_no_out_yet", out_valid, 0);
        tick();
        result = 32'hFFFFFFFA; result_parity = 0; result_rdy = 1;
        tick(); result_rdy = 0;
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_result", out_result, 32'hFFFFFFFA);
        chk("t1_out_status", out_status, 3'b000);
        out_ready = 1; tick(); out_ready = 0;
        chk("t1_out_done", out_valid, 0);
        chk("t1_idle", busy, 0);

        // flipped A parity, multiplier flags arg error; ack+rdy on same edge
        push1(16'd1, 16'd1, 1, 0);
        tick();
        chk("t2_pa", arg_a_parity, 0);
        chk("t2_pb", arg_b_parity, 1);
        ack = 1; result_rdy = 1; result = 0; result_parity = 0; arg_parity_error = 1;
        tick();
        ack = 0; result_rdy = 0; arg_parity_error = 0;
        chk("t2_out_valid", out_valid, 1);
        chk("t2_req", req, 0);
        chk("t2_status", out_status, 3'b001);
        chk("t2_result", out_result, 0);
        out_ready = 1; tick(); out_ready = 0;

        // bad result parity, then a stalled consumer with a pending entry
        push1(16'd1, 16'd1, 0, 0);
        tick();
        ack = 1; tick(); ack = 0;
        result = 32'h1; result_parity = 0; result_rdy = 1;
        tick(); result_rdy = 0;
        chk("t3_status", out_status, 3'b010);
        chk("t3_result", out_result, 32'h1);
        push1(16'd5, 16'd7, 0, 0);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("t3_stall_valid", out_valid, 1);
            chk("t3_stall_req", req, 0);
        end
        chk("t3_stall_result", out_result, 32'h1);
        chk("t3_stall_status", out_status, 3'b010);
        out_ready = 1; tick(); out_ready = 0;
        chk("t3_released", out_valid, 0);
        tick();
        chk("t3_next_req", req, 1);
        chk("t3_next_arg_a", arg_a, 32'h5);
        ack = 1; result_rdy = 1; result = 32'h23; result_parity = 1;
        tick(); ack = 0; result_rdy = 0;
        chk("t3_next_status", out_status, 3'b000);
        chk("t3_next_result", out_result, 32'h23);
        out_ready = 1; tick(); out_ready = 0;

        // FIFO fill with ack held low: 5 accepted, 6th refused
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; in_a = 16'(10 + i); in_b = 16'(20 + i);
            chk("t4_in_ready", in_ready, (i < 5) ? 1 : 0);
            tick();
        end
        in_valid = 0;
        chk("t4_full", in_ready, 0);
        for (int k = 0; k < 5; k++) begin
            wait_req();
            if (k == 1) chk("t4_ready_again", in_ready, 1);
            chk("t4_order_a", arg_a, 32'(10 + k));
            chk("t4_order_b", arg_b, 32'(20 + k));
            ack = 1; result_rdy = 1; result = 32'(k); result_parity = ^(32'(k));
            tick(); ack = 0; result_rdy = 0;
            chk("t4_out_result", out_result, 32'(k));
            chk("t4_out_status", out_status, 3'b000);
            out_ready = 1; tick(); out_ready = 0;
        end
        tick();
        chk("t4_drained", busy, 0);

        // timeout with ack never asserted
        push1(16'd7, 16'd9, 0, 0);
        tick();
        chk("t5_req", req, 1);
        for (int i = 0; i < 15; i++) tick();
        chk("t5_req_before_tmo", req, 1);
        chk("t5_no_out_before_tmo", out_valid, 0);
        tick();
        chk("t5_req_fall", req, 0);
        chk("t5_out_valid", out_valid, 1);
        chk("t5_out_result", out_result, 0);
        chk("t5_out_status", out_status, 3'b100);
        ack = 1; result_rdy = 1; result = 32'h55; tick(); ack = 0; result_rdy = 0;
        chk("t5_late_ack_status", out_status, 3'b100);
        chk("t5_late_ack_req", req, 0);
        out_ready = 1; tick(); out_ready = 0;
        ack = 1; tick(); ack = 0;
        chk("t5_idle_req", req, 0);
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_valid", out_valid, 0);

        // reset in WAIT_RES with another entry still buffered
        push1(16'd2, 16'd3, 0, 0);
        push1(16'd4, 16'd5, 0, 0);
        chk("t6_req", req, 1);
        ack = 1; tick(); ack = 0;
        rst = 1; tick(); rst = 0;
        chk("t6_req", req, 0);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_in_ready", in_ready, 1);
        chk("t6_busy", busy, 0);
        tick();
        result_rdy = 1; result = 32'h6; result_parity = 0; tick(); result_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t6_no_out", out_valid, 0);
            chk("t6_no_req", req, 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
